// File: rtl/zap_fifo_pkg.sv
// Shared sizing helpers for the FIFO family.
// Latency: n/a (constants and constant functions only).
// Backpressure: n/a.
//
// Helpers:
//   fifo_ptr_w(depth) - width of a read/write pointer addressing 'depth' entries
//   fifo_cnt_w(depth) - width of an occupancy count that can represent 0..depth
package zap_fifo_pkg;

    // Pointer width. A depth of 1 would give $clog2 == 0, so clamp to 1 bit
    // to keep the address ports legal.
    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count width. One extra bit over the pointer so that 'depth' itself is
    // representable (the full condition).
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : zap_fifo_pkg

// File: rtl/ram_simple.sv
// Simple dual-port storage: one write port, one read port with registered output.
// Latency: read data appears one cycle after i_rd_en; writes land on the same edge.
// Backpressure: none; caller guarantees legal addresses and enables.
//
// Ports:
//   i_clk                  - clock, all updates on rising edge
//   i_wr_en/i_wr_addr/i_wr_data - write port
//   i_rd_en/i_rd_addr      - read request; output register only loads when i_rd_en=1
//   o_rd_data              - registered read data, held stable between reads
module ram_simple
    import zap_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                          i_clk,
    input  logic                          i_wr_en,
    input  logic [fifo_ptr_w(DEPTH)-1:0]  i_wr_addr,
    input  logic [WIDTH-1:0]              i_wr_data,
    input  logic                          i_rd_en,
    input  logic [fifo_ptr_w(DEPTH)-1:0]  i_rd_addr,
    output logic [WIDTH-1:0]              o_rd_data
);

    // Storage array is written directly in the clocked block so that tools
    // map it to block RAM; it is deliberately never reset.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // Output register holds its value when no read is requested, which is
    // what lets the FIFO keep its head word stable without a separate copy.
    always_comb begin
        rd_data_d = rd_data_q;
        if (i_rd_en) begin
            rd_data_d = mem[i_rd_addr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign o_rd_data = rd_data_q;

endmodule : ram_simple

// File: rtl/bram_fifo.sv
// First-word-fall-through FIFO on a registered-read RAM, with a head stage hiding read latency.
// Latency: a push into an empty FIFO is visible on o_rd_data two cycles later; pops sustain 1/cycle.
// Backpressure: o_full refuses pushes (dropped, never stalled); pops while o_empty are ignored.
//
// Ports:
//   i_clk, i_reset          - clock and synchronous active-high reset
//   i_wr_en, i_wr_data      - push request and data; accepted iff o_full=0
//   o_full                  - registered, 1 iff o_count == DEPTH
//   i_rd_en                 - pop request; accepted iff o_empty=0
//   o_rd_data               - head word, valid whenever o_empty=0
//   o_empty                 - registered, 1 iff head stage holds no word
//   o_count                 - entries held, head word included
//   o_overflow, o_underflow - sticky error flags, present only when
//                             BRAM_FIFO_ERR_FLAG_EN is defined
module bram_fifo
    import zap_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_wr_en,
    input  logic [WIDTH-1:0]              i_wr_data,
    output logic                          o_full,
    input  logic                          i_rd_en,
    output logic [WIDTH-1:0]              o_rd_data,
    output logic                          o_empty,
    output logic [fifo_cnt_w(DEPTH)-1:0]  o_count
`ifdef BRAM_FIFO_ERR_FLAG_EN
    ,
    output logic                          o_overflow,
    output logic                          o_underflow
`endif
);

    localparam int PW = fifo_ptr_w(DEPTH);
    localparam int CW = fifo_cnt_w(DEPTH);

    // Storage pointers and storage-only occupancy (excludes the head word).
    logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [CW-1:0] mem_cnt_q, mem_cnt_d;

    // Total occupancy as seen by the user (storage + head).
    logic [CW-1:0] count_q,   count_d;

    // Head stage: the data half lives in the RAM output register, this is
    // the matching valid bit.
    logic          head_vld_q, head_vld_d;
    logic          full_q,     full_d;

    logic          push_acc;
    logic          pop_acc;
    logic          prefetch;
    logic          ram_wr_en;
    logic          ram_rd_en;
    logic [WIDTH-1:0] ram_rd_data;

    always_comb begin
        push_acc = i_wr_en & ~full_q;
        pop_acc  = i_rd_en & head_vld_q;

        // Refill the head whenever storage has something and the head is
        // either empty or being consumed this edge. Using the registered
        // storage count means a word written this cycle is never read this
        // cycle, so the RAM never sees a read/write collision.
        prefetch = (mem_cnt_q != '0) & (~head_vld_q | pop_acc);

        wr_ptr_d  = push_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = prefetch ? rd_ptr_q + PW'(1) : rd_ptr_q;
        mem_cnt_d = mem_cnt_q + CW'(push_acc) - CW'(prefetch);
        count_d   = count_q   + CW'(push_acc) - CW'(pop_acc);

        head_vld_d = head_vld_q;
        if (prefetch) begin
            head_vld_d = 1'b1;
        end else if (pop_acc) begin
            head_vld_d = 1'b0;
        end

        full_d = (count_d == CW'(DEPTH));

        // Nothing reaches the RAM during reset so the reset cycle has no
        // side effects beyond clearing state.
        ram_wr_en = push_acc & ~i_reset;
        ram_rd_en = prefetch & ~i_reset;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            count_q    <= '0;
            head_vld_q <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            count_q    <= count_d;
            head_vld_q <= head_vld_d;
            full_q     <= full_d;
        end
    end

    ram_simple #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (ram_wr_en),
        .i_wr_addr (wr_ptr_q),
        .i_wr_data (i_wr_data),
        .i_rd_en   (ram_rd_en),
        .i_rd_addr (rd_ptr_q),
        .o_rd_data (ram_rd_data)
    );

    assign o_rd_data = ram_rd_data;
    assign o_empty   = ~head_vld_q;
    assign o_full    = full_q;
    assign o_count   = count_q;

`ifdef BRAM_FIFO_ERR_FLAG_EN
    // Sticky error flags; only reset clears them.
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (i_wr_en & full_q);
        underflow_d = underflow_q | (i_rd_en & ~head_vld_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;
`endif

endmodule : bram_fifo

// File: tb/tb_bram_fifo.sv
// Directed bench for bram_fifo (WIDTH=32, DEPTH=4) with a scoreboard monitor.
// Stimulus queues the words it expects to emerge; the monitor pops on every accepted read.
// Status outputs (count/full/empty/flags) are compared against hand-computed constants.
module tb_bram_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             i_clk;
    logic             i_reset;
    logic             i_wr_en;
    logic [WIDTH-1:0] i_wr_data;
    logic             o_full;
    logic             i_rd_en;
    logic [WIDTH-1:0] o_rd_data;
    logic             o_empty;
    logic [2:0]       o_count;
`ifdef BRAM_FIFO_ERR_FLAG_EN
    logic             o_overflow;
    logic             o_underflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] exp_q [$];

    bram_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (i_wr_en),
        .i_wr_data (i_wr_data),
        .o_full    (o_full),
        .i_rd_en   (i_rd_en),
        .o_rd_data (o_rd_data),
        .o_empty   (o_empty),
        .o_count   (o_count)
`ifdef BRAM_FIFO_ERR_FLAG_EN
        ,
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; returns 1 time unit after the edge.
    task automatic step(input logic wr, input logic [31:0] d, input logic rd);
        i_wr_en   = wr;
        i_wr_data = d;
        i_rd_en   = rd;
        @(posedge i_clk);
        #1;
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
    endtask

    // Push with the scenario's own knowledge of whether it should be accepted.
    task automatic push(input logic [31:0] d, input bit accept);
        if (accept) exp_q.push_back(d);
        step(1'b1, d, 1'b0);
    endtask

    task automatic status(input string tag, input int cnt, input logic full, input logic empty);
        chk({tag, ".count"}, 32'(o_count), 32'(cnt));
        chk({tag, ".full"},  32'(o_full),  32'(full));
        chk({tag, ".empty"}, 32'(o_empty), 32'(empty));
    endtask

    task automatic do_reset(input logic wr, input logic rd);
        exp_q.delete();
        i_reset = 1'b1;
        step(wr, 32'h99, rd);
        i_reset = 1'b0;
    endtask

    // Scoreboard monitor: a pop is accepted on the coming edge whenever
    // i_rd_en is high, o_empty is low and reset is not asserted.
    always @(negedge i_clk) begin
        if (!i_reset && i_rd_en && !o_empty) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got %0h, expected no word", o_rd_data);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (o_rd_data !== e) begin
                    n_fail++;
                    $display("FAIL pop_data: got %0h, expected %0h", o_rd_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        i_reset   = 1'b1;
        i_wr_en   = 1'b0;
        i_wr_data = '0;
        i_rd_en   = 1'b0;
        @(posedge i_clk);
        #1;
        do_reset(1'b0, 1'b0);
        status("reset", 0, 1'b0, 1'b1);
`ifdef BRAM_FIFO_ERR_FLAG_EN
        chk("reset.ovf", 32'(o_overflow), 0);
        chk("reset.udf", 32'(o_underflow), 0);
`endif

        // First-word latency: push in cycle 0, visible in cycle 2.
        push(32'hA5A5A5A5, 1'b1);
        status("fwft.c1", 1, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0);
        status("fwft.c2", 1, 1'b0, 1'b0);
        chk("fwft.data", o_rd_data, 32'hA5A5A5A5);
        step(1'b0, 0, 1'b0);
        chk("fwft.hold", o_rd_data, 32'hA5A5A5A5);
        step(1'b0, 0, 1'b1);
        status("fwft.drained", 0, 1'b0, 1'b1);

        // Fill to full, drop an extra push, drain in order.
        push(32'd1, 1'b1);
        push(32'd2, 1'b1);
        push(32'd3, 1'b1);
        push(32'd4, 1'b1);
        status("fill", 4, 1'b1, 1'b0);
        push(32'd5, 1'b0);
        status("fill.drop", 4, 1'b1, 1'b0);
`ifdef BRAM_FIFO_ERR_FLAG_EN
        chk("fill.ovf", 32'(o_overflow), 1);
`endif
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1);
        status("drain", 0, 1'b0, 1'b1);

        // Full with simultaneous pop: push still dropped.
        for (int i = 0; i < 4; i++) push(32'd11 + 32'(i), 1'b1);
        status("full2", 4, 1'b1, 1'b0);
        step(1'b1, 32'd15, 1'b1);
        status("full_pop", 3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1);
        status("full_pop.drain", 0, 1'b0, 1'b1);

        // Steady streaming: push and pop every cycle, count stays 2, pointers wrap.
        push(32'd100, 1'b1);
        push(32'd101, 1'b1);
        status("stream.pre", 2, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(32'd102 + 32'(i));
            step(1'b1, 32'd102 + 32'(i), 1'b1);
            chk("stream.count", 32'(o_count), 2);
        end
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        status("stream.drain", 0, 1'b0, 1'b1);

        // Pop while empty: no state change.
        step(1'b0, 0, 1'b1);
        status("udf", 0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0);
        status("udf.after", 0, 1'b0, 1'b1);
`ifdef BRAM_FIFO_ERR_FLAG_EN
        chk("udf.flag", 32'(o_underflow), 1);
`endif

        // Reset with three entries held; push/pop in the reset cycle ignored.
        push(32'd31, 1'b1);
        push(32'd32, 1'b1);
        push(32'd33, 1'b1);
        step(1'b0, 0, 1'b0);
        status("mid.pre", 3, 1'b0, 1'b0);
        do_reset(1'b1, 1'b1);
        status("mid.rst", 0, 1'b0, 1'b1);
`ifdef BRAM_FIFO_ERR_FLAG_EN
        chk("mid.ovf", 32'(o_overflow), 0);
        chk("mid.udf", 32'(o_underflow), 0);
`endif

        // Reset while a prefetch is in flight: the word must not appear.
        push(32'd41, 1'b0);
        do_reset(1'b0, 1'b0);
        step(1'b0, 0, 1'b0);
        status("flight.rst", 0, 1'b0, 1'b1);

        // A following push of 7 emerges normally.
        push(32'd7, 1'b1);
        step(1'b0, 0, 1'b0);
        status("post", 1, 1'b0, 1'b0);
        chk("post.data", o_rd_data, 32'd7);
        step(1'b0, 0, 1'b1);
        status("post.drain", 0, 1'b0, 1'b1);

        chk("scoreboard.left", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bram_fifo

// File: doc/bram_fifo.md
BRAM_FIFO -- requirements
Module: bram_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, total entry capacity; power of two, 4 to 4096.
REQ-003 SHALL have port i_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_wr_en, input, 1 bit: push request.
REQ-006 SHALL have port i_wr_data, input, WIDTH bits: push data.
REQ-007 SHALL have port o_full, output, 1 bit: no push is accepted this cycle.
REQ-008 SHALL have port i_rd_en, input, 1 bit: pop request.
REQ-009 SHALL have port o_rd_data, output, WIDTH bits: head word, first-word-fall-through, valid whenever o_empty is 0.
REQ-010 SHALL have port o_empty, output, 1 bit: no valid head word.
REQ-011 SHALL have port o_count, output, $clog2(DEPTH)+1 bits: entries held, including the head word.

Function
REQ-012 SHALL accept a push iff i_wr_en=1 and o_full=0, writing i_wr_data at the write pointer, which then increments modulo DEPTH.
REQ-013 SHALL accept a pop iff i_rd_en=1 and o_empty=0; the head word is consumed that edge.
REQ-014 SHALL hide the 1-cycle storage read latency with a head stage (valid bit plus registered read data): prefetch the next word whenever storage occupancy >0 and the head is invalid or being popped.
REQ-015 SHALL issue prefetches only against registered storage occupancy, so no prefetch reads the address being written in the same cycle.
REQ-016 SHALL show a word pushed in cycle N into an empty FIFO on o_rd_data with o_empty=0 in cycle N+2.
REQ-017 SHALL sustain back-to-back pops of one word per cycle, with no bubble, while storage occupancy >0.
REQ-018 SHALL drive o_full=1 iff o_count==DEPTH, and o_empty=1 iff the head stage is invalid; both are registered.
REQ-019 SHALL, on simultaneous accepted push and pop, leave o_count unchanged.
REQ-020 SHALL, when full, drop a push even if a pop occurs in the same cycle.
REQ-021 SHALL, when empty, ignore a pop with no state change.
REQ-022 SHALL wrap the read and write pointers from DEPTH-1 to 0 with no gap.
REQ-023 SHALL hold o_rd_data stable while o_empty=0 and no pop occurs.

Reset
REQ-024 SHALL, on reset, clear both pointers, o_count and the head valid bit, giving o_empty=1 and o_full=0; any push or pop in the reset cycle is ignored.
REQ-025 SHALL NOT clear storage contents on reset; o_rd_data is don't-care while o_empty=1.
REQ-026 SHALL, on reset asserted mid-stream, discard all entries including an in-flight prefetch.

Configuration
REQ-027 SHALL, with BRAM_FIFO_ERR_FLAG_EN defined, add outputs o_overflow and o_underflow (1 bit each): sticky, set on a push when full or a pop when empty respectively, cleared only by reset.
REQ-028 SHALL, without BRAM_FIFO_ERR_FLAG_EN, omit both ports and their logic; data-path behaviour is identical with and without the macro.

Structure
REQ-029 SHALL instantiate ram_simple (WIDTH, DEPTH) as its single storage sub-module; no other sub-modules.
REQ-030 SHALL place the pointer-width and count-width helper constants in the shared package zap_fifo_pkg.

Verification
REQ-031 SHALL cover: WIDTH=32, DEPTH=4, reset, push 0xA5A5A5A5 in cycle 0 -> o_empty=0 and o_rd_data=0xA5A5A5A5 in cycle 2.
REQ-032 SHALL cover: push 1,2,3,4 -> o_full=1, o_count=4; push 5 -> dropped; then four pops -> 1,2,3,4, o_empty=1.
REQ-033 SHALL cover: steady push and pop every cycle for 20 cycles -> in-order output, o_count constant, pointers wrap.
REQ-034 SHALL cover: pop while empty -> no change; with BRAM_FIFO_ERR_FLAG_EN, o_underflow=1 until reset.
REQ-035 SHALL cover: reset asserted with 3 entries held -> next cycle o_count=0, o_empty=1; a following push of 7 -> 7 emerges.
